// File: rtl/freq_band_search_multi.sv
// DCO coarse-band search controller.
// Measures DCO frequency per band over a fixed window and searches for the
// lowest band that reaches the target. It supports a linear sweep with
// one-step back-off, or a binary (successive-approximation) search.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start after reset
// SETTLE  | DCO settling after a band change; base count taken on last cycle
// MEASURE | counting DCO cycles over NCYC clk periods
// DECIDE  | evaluate err, pick next band or finish
// PASS    | band found; holds until start or reset
// FAIL    | no band in range reaches target; holds until start or reset
module freq_band_search_multi #(
    parameter int BAND_W     = 6,
    parameter int MINBAND    = -5,
    parameter int MAXBAND    = 31,
    parameter int CNT_W      = 16,
    parameter int TGT_W      = 12,
    parameter int NCYC       = 32,
    parameter int SETTLE_CYC = 4,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [TGT_W-1:0]  target,
    input  logic [CNT_W-1:0]  meas_count,
    output logic [BAND_W-1:0] band,
    output logic [2:0]        state,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  meas_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_PASS    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    localparam int LOG2_NCYC = $clog2(NCYC);
    localparam int TMR_MAX   = (NCYC > SETTLE_CYC) ? NCYC : SETTLE_CYC;
    localparam int TMR_W     = $clog2(TMR_MAX) + 1;
    localparam int PROD_W    = TGT_W + LOG2_NCYC;
    // Two guard bits so the difference of two non-negative operands never overflows.
    localparam int FULL_W    = ((CNT_W > PROD_W) ? CNT_W : PROD_W) + 2;
    localparam int EW        = (FULL_W > ERR_W) ? FULL_W : ERR_W;

    localparam logic [TMR_W-1:0]         SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]         MEAS_LD   = TMR_W'(NCYC - 1);
    localparam logic [TMR_W-1:0]         TMR_ZERO  = '0;
    localparam logic signed [BAND_W-1:0] MINB      = BAND_W'(MINBAND);
    localparam logic signed [BAND_W-1:0] MAXB      = BAND_W'(MAXBAND);
    localparam logic signed [BAND_W-1:0] ONE_B     = BAND_W'(1);
    localparam logic signed [EW-1:0]     ERR_POS   = EW'((longint'(1) << (ERR_W - 1)) - 1);
    localparam logic signed [EW-1:0]     ERR_NEG   = EW'(-((longint'(1) << (ERR_W - 1)) - 1));

    // floor((a+b)/2): one extra bit for the sum, then arithmetic shift right.
    function automatic logic signed [BAND_W-1:0] band_mid(
        input logic signed [BAND_W-1:0] a,
        input logic signed [BAND_W-1:0] b
    );
        logic signed [BAND_W:0] s;
        s = {a[BAND_W-1], a} + {b[BAND_W-1], b};
        return s[BAND_W:1];
    endfunction

    state_t                   state_q, state_d;
    logic signed [BAND_W-1:0] band_q, band_d;
    logic signed [BAND_W-1:0] lo_q, lo_d;
    logic signed [BAND_W-1:0] hi_q, hi_d;
    logic                     mode_q, mode_d;
    logic [TGT_W-1:0]         target_q, target_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [CNT_W-1:0]         base_q, base_d;
    logic [CNT_W-1:0]         fmeas_q, fmeas_d;
    logic signed [EW-1:0]     prev_err_q, prev_err_d;
    logic                     prev_valid_q, prev_valid_d;
    logic [ERR_W-1:0]         meas_err_q, meas_err_d;
    logic                     done_q, done_d;

    logic signed [EW-1:0]     err;
    logic signed [EW-1:0]     err_sat;
    logic signed [EW-1:0]     neg_prev_err;
    logic                     err_neg;
    logic signed [BAND_W-1:0] bin_lo_nxt;
    logic signed [BAND_W-1:0] bin_hi_nxt;
    logic signed [BAND_W-1:0] bin_mid_nxt;

    assign err          = $signed(EW'(fmeas_q)) - $signed(EW'(target_q) << LOG2_NCYC);
    assign err_neg      = err[EW-1];
    assign neg_prev_err = -prev_err_q;

    // Clamp the reported error symmetrically to the output range.
    always_comb begin
        err_sat = err;
        if (err > ERR_POS) begin
            err_sat = ERR_POS;
        end else if (err < ERR_NEG) begin
            err_sat = ERR_NEG;
        end
    end

    // Binary-search interval update and the next probe band.
    always_comb begin
        bin_lo_nxt  = err_neg ? (band_q + ONE_B) : lo_q;
        bin_hi_nxt  = err_neg ? hi_q : band_q;
        bin_mid_nxt = band_mid(bin_lo_nxt, bin_hi_nxt);
    end

    // Next-state and datapath updates for the search FSM.
    always_comb begin
        state_d      = state_q;
        band_d       = band_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        mode_d       = mode_q;
        target_d     = target_q;
        tmr_d        = tmr_q;
        base_d       = base_q;
        fmeas_d      = fmeas_q;
        prev_err_d   = prev_err_q;
        prev_valid_d = prev_valid_q;
        meas_err_d   = meas_err_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    mode_d   = mode;
                    target_d = target;
                    tmr_d    = SETTLE_LD;
                    state_d  = ST_SETTLE;
                    if (!mode) begin
                        band_d       = MINB;
                        prev_valid_d = 1'b0;
                    end else begin
                        lo_d   = MINB;
                        hi_d   = MAXB;
                        band_d = band_mid(MINB, MAXB);
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_q == TMR_ZERO) begin
                    base_d  = meas_count;
                    tmr_d   = MEAS_LD;
                    state_d = ST_MEASURE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_MEASURE: begin
                if (tmr_q == TMR_ZERO) begin
                    fmeas_d = meas_count - base_q;
                    state_d = ST_DECIDE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_DECIDE: begin
                meas_err_d = err_sat[ERR_W-1:0];
                tmr_d      = SETTLE_LD;
                if (!mode_q) begin
                    if (!err_neg) begin
                        state_d = ST_PASS;
                        done_d  = 1'b1;
                        // Step back when the band below landed strictly closer.
                        if (prev_valid_q && (band_q > MINB) && (neg_prev_err < err)) begin
                            band_d = band_q - ONE_B;
                        end
                    end else if (band_q == MAXB) begin
                        state_d = ST_FAIL;
                        done_d  = 1'b1;
                    end else begin
                        prev_err_d   = err;
                        prev_valid_d = 1'b1;
                        band_d       = band_q + ONE_B;
                        state_d      = ST_SETTLE;
                    end
                end else begin
                    if (lo_q == hi_q) begin
                        state_d = err_neg ? ST_FAIL : ST_PASS;
                        done_d  = 1'b1;
                    end else begin
                        lo_d    = bin_lo_nxt;
                        hi_d    = bin_hi_nxt;
                        band_d  = bin_mid_nxt;
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            band_q       <= MINB;
            lo_q         <= '0;
            hi_q         <= '0;
            mode_q       <= 1'b0;
            target_q     <= '0;
            tmr_q        <= '0;
            base_q       <= '0;
            fmeas_q      <= '0;
            prev_err_q   <= '0;
            prev_valid_q <= 1'b0;
            meas_err_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            band_q       <= band_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            mode_q       <= mode_d;
            target_q     <= target_d;
            tmr_q        <= tmr_d;
            base_q       <= base_d;
            fmeas_q      <= fmeas_d;
            prev_err_q   <= prev_err_d;
            prev_valid_q <= prev_valid_d;
            meas_err_q   <= meas_err_d;
            done_q       <= done_d;
        end
    end

    assign band     = band_q;
    assign state    = state_q;
    assign busy     = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) || (state_q == ST_DECIDE);
    assign done     = done_q;
    assign meas_err = meas_err_q;

endmodule

// File: tb/tb_freq_band_search_multi.sv
// Bench for freq_band_search_multi. Two instances share start/mode/target:
// one at default parameters, one with MINBAND=0 and a 12-bit wrapping count.
// Each has its own DCO model whose rate depends on the band it drives.
module tb_freq_band_search_multi;

    localparam int MEAS_CYC = 4 + 32 + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [11:0] target;
    logic        preload;

    logic [15:0] meas_a;
    logic [5:0]  band_a;
    logic [2:0]  state_a;
    logic        busy_a, done_a;
    logic [15:0] err_a;

    logic [11:0] meas_b;
    logic [5:0]  band_b;
    logic [2:0]  state_b;
    logic        busy_b, done_b;
    logic [15:0] err_b;

    // DCO rate per band in quarter cycles per clk
    int          rate4_tab [-32:31];
    logic [63:0] acc_a, acc_b;

    int n_chk = 0;
    int n_err = 0;

    freq_band_search_multi dut_a (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .target(target),
        .meas_count(meas_a), .band(band_a), .state(state_a), .busy(busy_a),
        .done(done_a), .meas_err(err_a)
    );

    freq_band_search_multi #(.MINBAND(0), .MAXBAND(31), .CNT_W(12)) dut_b (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .target(target),
        .meas_count(meas_b), .band(band_b), .state(state_b), .busy(busy_b),
        .done(done_b), .meas_err(err_b)
    );

    always #5 clk = ~clk;

    // DCO models: fractional accumulators in quarter cycles, preloaded near wrap
    always @(posedge clk) begin
        if (preload) begin
            acc_a <= 64'(65530 * 4);
            acc_b <= 64'(4090 * 4);
        end else begin
            acc_a <= acc_a + 64'(rate4_tab[int'($signed(band_a))]);
            acc_b <= acc_b + 64'(rate4_tab[int'($signed(band_b))]);
        end
    end
    assign meas_a = acc_a[17:2];
    assign meas_b = acc_b[13:2];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_default_rates();
        for (int b = -32; b <= 31; b++) rate4_tab[b] = 4 * (20 + b);
    endtask

    // Error seen over a 32-cycle window at band b (count wraps at 2^cnt_w).
    function automatic longint win_err(int b, int tgt, int cnt_w);
        longint f;
        f = ((longint'(rate4_tab[b]) * 32) / 4) % (longint'(1) << cnt_w);
        return f - longint'(tgt) * 32;
    endfunction

    // Reference search: outcome band, final state (4 PASS / 5 FAIL),
    // last saturated error and number of measurements.
    task automatic model(input int md, input int tgt, input int minb, input int maxb,
                         input int cnt_w, output int eband, output int estate,
                         output longint eerr, output int ek);
        longint e, prev;
        bit     pv;
        int     b, lo, hi;
        ek = 0; prev = 0; pv = 0; e = 0;
        eband = minb; estate = 0;
        if (md == 0) begin
            for (b = minb; b <= maxb; b++) begin
                e = win_err(b, tgt, cnt_w);
                ek++;
                if (e >= 0) begin
                    estate = 4;
                    eband  = (pv && b > minb && -prev < e) ? b - 1 : b;
                    break;
                end
                if (b == maxb) begin
                    estate = 5;
                    eband  = b;
                    break;
                end
                prev = e;
                pv   = 1;
            end
        end else begin
            lo = minb;
            hi = maxb;
            b  = (lo + hi) >>> 1;
            for (int it = 0; it < 64; it++) begin
                e = win_err(b, tgt, cnt_w);
                ek++;
                if (lo == hi) begin
                    estate = (e >= 0) ? 4 : 5;
                    eband  = b;
                    break;
                end
                if (e >= 0) hi = b;
                else        lo = b + 1;
                b = (lo + hi) >>> 1;
            end
        end
        if (e > 32767)       eerr = 32767;
        else if (e < -32767) eerr = -32767;
        else                 eerr = e;
    endtask

    task automatic run_search(input string name, input int md, input int tgt, input bit poke);
        int     eb_a, es_a, k_a, eb_b, es_b, k_b;
        longint ee_a, ee_b;
        int     lat_a, lat_b, cyc, pulses_a, pulses_b;
        logic [5:0] band_hold_a, band_hold_b;
        model(md, tgt, -5, 31, 16, eb_a, es_a, ee_a, k_a);
        model(md, tgt, 0, 31, 12, eb_b, es_b, ee_b, k_b);
        @(negedge clk);
        start  = 1'b1;
        mode   = md[0];
        target = 12'(tgt);
        lat_a = 0; lat_b = 0; cyc = 0; pulses_a = 0; pulses_b = 0;
        while ((lat_a == 0 || lat_b == 0) && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            // Inputs scrambled after acceptance: they must have been latched.
            mode   = 1'($urandom);
            target = 12'($urandom_range(0, 127));
            start  = poke && busy_a && busy_b && (cyc % 23 == 5);
            if (done_a) pulses_a++;
            if (done_b) pulses_b++;
            if (done_a && lat_a == 0) lat_a = cyc;
            if (done_b && lat_b == 0) lat_b = cyc;
        end
        start = 1'b0;
        check_val({name, "_a_latency"}, lat_a, 1 + MEAS_CYC * k_a);
        check_val({name, "_b_latency"}, lat_b, 1 + MEAS_CYC * k_b);
        check_val({name, "_a_state"}, state_a, es_a);
        check_val({name, "_b_state"}, state_b, es_b);
        check_val({name, "_a_band"}, int'($signed(band_a)), eb_a);
        check_val({name, "_b_band"}, int'($signed(band_b)), eb_b);
        check_val({name, "_a_err"}, longint'($signed(err_a)), ee_a);
        check_val({name, "_b_err"}, longint'($signed(err_b)), ee_b);
        check_val({name, "_a_busy"}, busy_a, 0);
        check_val({name, "_b_busy"}, busy_b, 0);
        band_hold_a = band_a;
        band_hold_b = band_b;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_a) pulses_a++;
            if (done_b) pulses_b++;
        end
        check_val({name, "_a_pulses"}, pulses_a, 1);
        check_val({name, "_b_pulses"}, pulses_b, 1);
        check_val({name, "_a_hold"}, band_a, band_hold_a);
        check_val({name, "_b_hold"}, band_b, band_hold_b);
        check_val({name, "_a_state_hold"}, state_a, es_a);
    endtask

    initial begin
        int cyc, ndone;
        set_default_rates();
        reset   = 1'b1;
        preload = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        target  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_state_a", state_a, 0);
        check_val("rst_band_a", int'($signed(band_a)), -5);
        check_val("rst_busy_a", busy_a, 0);
        check_val("rst_done_a", done_a, 0);
        check_val("rst_err_a", err_a, 0);
        check_val("rst_state_b", state_b, 0);
        check_val("rst_band_b", int'($signed(band_b)), 0);
        @(negedge clk);
        reset   = 1'b0;
        preload = 1'b0;

        run_search("lin_hit", 0, 25, 1'b0);

        rate4_tab[3] = 97;
        rate4_tab[4] = 104;
        run_search("backoff", 0, 25, 1'b0);
        rate4_tab[4] = 103;
        run_search("tie", 0, 25, 1'b0);
        set_default_rates();

        run_search("bin", 1, 25, 1'b0);
        run_search("oor_lin", 0, 60, 1'b0);
        run_search("oor_bin", 1, 60, 1'b0);
        run_search("poke_lin", 0, 30, 1'b1);
        run_search("poke_bin", 1, 30, 1'b1);

        // Reset in the middle of a measurement window.
        @(negedge clk);
        start  = 1'b1;
        mode   = 1'b0;
        target = 12'd25;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (state_a != 3'd2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_val("rstmid_reach", state_a, 2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rstmid_state_a", state_a, 0);
        check_val("rstmid_band_a", int'($signed(band_a)), -5);
        check_val("rstmid_busy_a", busy_a, 0);
        check_val("rstmid_state_b", state_b, 0);
        check_val("rstmid_band_b", int'($signed(band_b)), 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_a || done_b) ndone++;
        end
        check_val("rstmid_no_done", ndone, 0);
        check_val("rstmid_idle", state_a, 0);

        // Randomized rate tables, targets and modes.
        for (int r = 0; r < 8; r++) begin
            for (int b = -5; b <= 31; b++)
                rate4_tab[b] = 4 * (20 + b) + int'($urandom_range(0, 6)) - 3;
            run_search($sformatf("rnd%0d", r), int'($urandom_range(0, 1)),
                       int'($urandom_range(15, 55)), 1'(r % 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
